// File: rtl/spi_target.sv
// SPI mode-0 target: 8-bit MSB-first frames with a single-entry transmit holding
// register, oversampled SCLK/CS/COPI via 2-flop synchronizers in the clk_i domain.
module spi_target #(
    parameter logic [7:0] TxIdleByte = 8'hFF
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       sclk_i,
    input  logic       cs_ni,
    input  logic       copi_i,
    output logic       cipo_o,
    output logic       cipo_en_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       tx_underrun_o
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t     state_reg;
    logic       sclk_s1_reg, sclk_s2_reg, sclk_d_reg;
    logic       cs_s1_reg, cs_s2_reg, cs_d_reg;
    logic       copi_s1_reg, copi_s2_reg;
    logic [7:0] tx_shift_reg;
    logic [7:0] rx_shift_reg;
    logic [7:0] hold_reg;
    logic [2:0] bit_cnt_reg;

    logic sclk_rise, sclk_fall, cs_fall, load_tx;

    // Synchronizers reset to the bus idle levels so reset never fakes an edge on SCLK.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_s1_reg <= 1'b0;
            sclk_s2_reg <= 1'b0;
            sclk_d_reg  <= 1'b0;
            cs_s1_reg   <= 1'b1;
            cs_s2_reg   <= 1'b1;
            cs_d_reg    <= 1'b1;
            copi_s1_reg <= 1'b0;
            copi_s2_reg <= 1'b0;
        end else begin
            sclk_s1_reg <= sclk_i;
            sclk_s2_reg <= sclk_s1_reg;
            sclk_d_reg  <= sclk_s2_reg;
            cs_s1_reg   <= cs_ni;
            cs_s2_reg   <= cs_s1_reg;
            cs_d_reg    <= cs_s2_reg;
            copi_s1_reg <= copi_i;
            copi_s2_reg <= copi_s1_reg;
        end
    end

    assign sclk_rise = sclk_s2_reg & ~sclk_d_reg;
    assign sclk_fall = ~sclk_s2_reg & sclk_d_reg;
    assign cs_fall   = ~cs_s2_reg & cs_d_reg;

    // The tx shifter is (re)loaded at selection and at each byte boundary falling edge.
    always_comb begin
        load_tx = 1'b0;
        if (state_reg == IDLE) begin
            load_tx = cs_fall;
        end else if (!cs_s2_reg && sclk_fall && (bit_cnt_reg == 3'd0)) begin
            load_tx = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg     <= IDLE;
            tx_shift_reg  <= 8'h00;
            rx_shift_reg  <= 8'h00;
            hold_reg      <= 8'h00;
            bit_cnt_reg   <= 3'd0;
            rx_data_o     <= 8'h00;
            rx_valid_o    <= 1'b0;
            tx_ready_o    <= 1'b1;
            tx_underrun_o <= 1'b0;
        end else begin
            rx_valid_o    <= 1'b0;
            tx_underrun_o <= 1'b0;

            // tx_ready_o doubles as the holding-register-empty flag.
            if (tx_valid_i && tx_ready_o) begin
                hold_reg   <= tx_data_i;
                tx_ready_o <= 1'b0;
            end else if (load_tx && !tx_ready_o) begin
                tx_ready_o <= 1'b1;
            end

            if (load_tx) begin
                tx_shift_reg  <= tx_ready_o ? TxIdleByte : hold_reg;
                tx_underrun_o <= tx_ready_o;
            end

            case (state_reg)
                IDLE: begin
                    if (cs_fall) begin
                        state_reg   <= ACTIVE;
                        bit_cnt_reg <= 3'd0;
                    end
                end
                ACTIVE: begin
                    if (cs_s2_reg) begin
                        state_reg   <= IDLE;
                        bit_cnt_reg <= 3'd0;
                    end else if (sclk_rise) begin
                        rx_shift_reg <= {rx_shift_reg[6:0], copi_s2_reg};
                        bit_cnt_reg  <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            rx_data_o  <= {rx_shift_reg[6:0], copi_s2_reg};
                            rx_valid_o <= 1'b1;
                        end
                    end else if (sclk_fall && (bit_cnt_reg != 3'd0)) begin
                        tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign cipo_en_o = (state_reg == ACTIVE);
    assign cipo_o    = (state_reg == ACTIVE) & tx_shift_reg[7];

endmodule

// File: tb/tb_spi_target.sv
// Scoreboard bench for spi_target: stimulus pushes expected rx/tx bytes into queues,
// independent monitors pop and compare when rx_valid_o pulses or a CIPO byte completes.
module tb_spi_target;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       copi = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       cipo_o, cipo_en_o, rx_valid_o, tx_ready_o, tx_underrun_o;
    logic [7:0] rx_data_o;

    spi_target #(.TxIdleByte(8'hFF)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .sclk_i       (sclk),
        .cs_ni        (cs_n),
        .copi_i       (copi),
        .cipo_o       (cipo_o),
        .cipo_en_o    (cipo_en_o),
        .rx_data_o    (rx_data_o),
        .rx_valid_o   (rx_valid_o),
        .tx_data_i    (tx_data),
        .tx_valid_i   (tx_valid),
        .tx_ready_o   (tx_ready_o),
        .tx_underrun_o(tx_underrun_o)
    );

    always #5 clk = ~clk;

    int checks_total = 0;
    int checks_pass  = 0;
    int rx_pulses    = 0;
    int underrun_cnt = 0;
    int cipo_bits    = 0;
    logic [7:0] cipo_byte = 8'h00;

    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];

    // Reference model of the holding register
    logic [7:0] m_hold = 8'h00;
    bit         m_full = 1'b0;
    int         m_underruns = 0;
    logic [7:0] frame_rx[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // rx monitor
    always @(negedge clk) begin
        if (rx_valid_o) begin
            rx_pulses++;
            if (exp_rx.size() == 0) begin
                checks_total++;
                $display("FAIL rx_unexpected: got %0h expected no rx_valid_o at %0t", rx_data_o, $time);
            end else begin
                logic [7:0] e;
                e = exp_rx.pop_front();
                check("rx_data", {24'h0, rx_data_o}, {24'h0, e});
                $display("rx byte %02h (expected %02h)", rx_data_o, e);
            end
        end
        if (tx_underrun_o) underrun_cnt++;
    end

    // CIPO monitor: samples late in the high phase, just before SCLK falls
    always @(negedge sclk or posedge cs_n) begin
        if (cs_n) begin
            cipo_bits = 0;
        end else begin
            cipo_byte = {cipo_byte[6:0], cipo_o};
            cipo_bits++;
            if (cipo_bits == 8) begin
                cipo_bits = 0;
                if (exp_tx.size() == 0) begin
                    checks_total++;
                    $display("FAIL cipo_unexpected: got %0h expected no byte at %0t", cipo_byte, $time);
                end else begin
                    logic [7:0] e;
                    e = exp_tx.pop_front();
                    check("cipo_byte", {24'h0, cipo_byte}, {24'h0, e});
                    $display("cipo byte %02h (expected %02h)", cipo_byte, e);
                end
            end
        end
    end

    task automatic model_load(input bit push);
        if (m_full) begin
            if (push) exp_tx.push_back(m_hold);
            m_full = 1'b0;
        end else begin
            if (push) exp_tx.push_back(8'hFF);
            m_underruns++;
        end
    endtask

    task automatic queue_tx(input logic [7:0] d);
        int n;
        n = 0;
        while (!tx_ready_o && n < 50) begin
            wait_clk(1);
            n++;
        end
        if (n >= 50) check("tx_ready_timeout", 32'd0, 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        wait_clk(1);
        tx_valid = 1'b0;
        m_hold   = d;
        m_full   = 1'b1;
        check("tx_ready_after_accept", {31'h0, tx_ready_o}, 32'd0);
    endtask

    task automatic spi_bits(input logic [7:0] d, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            copi = d[i];
            wait_clk(2);
            sclk = 1'b1;
            wait_clk(2);
            sclk = 1'b0;
        end
    endtask

    task automatic run_frame(input int nbytes, input bit mid_q, input logic [7:0] mid_byte);
        int u0, a0, r0;
        u0 = m_underruns;
        a0 = underrun_cnt;
        r0 = rx_pulses;
        cs_n = 1'b0;
        model_load(1'b1);
        wait_clk(4);
        check("underrun_at_select", underrun_cnt - a0, m_underruns - u0);
        check("cipo_en_active", {31'h0, cipo_en_o}, 32'd1);
        if (mid_q) begin
            check("tx_ready_after_load", {31'h0, tx_ready_o}, 32'd1);
            queue_tx(mid_byte);
        end
        for (int b = 0; b < nbytes; b++) begin
            exp_rx.push_back(frame_rx[b]);
            spi_bits(frame_rx[b], 8);
            model_load(b < nbytes - 1);
            wait_clk(4);
            check("tx_ready_model", {31'h0, tx_ready_o}, {31'h0, !m_full});
        end
        cs_n = 1'b1;
        wait_clk(6);
        check("cipo_en_idle", {31'h0, cipo_en_o}, 32'd0);
        check("underrun_total", underrun_cnt - a0, m_underruns - u0);
        check("rx_pulse_count", rx_pulses - r0, nbytes);
        $display("frame bytes=%0d done, underruns=%0d", nbytes, underrun_cnt - a0);
    endtask

    task automatic abort_frame(input logic [7:0] d, input int nbits);
        int r0;
        r0 = rx_pulses;
        cs_n = 1'b0;
        model_load(1'b0);
        wait_clk(4);
        spi_bits(d, nbits);
        wait_clk(1);
        cs_n = 1'b1;
        wait_clk(6);
        check("abort_no_rx", rx_pulses - r0, 32'd0);
        check("abort_cipo_en", {31'h0, cipo_en_o}, 32'd0);
        check("abort_cipo", {31'h0, cipo_o}, 32'd0);
        $display("aborted frame after %0d bits", nbits);
    endtask

    task automatic check_reset_outputs();
        check("rst_cipo", {31'h0, cipo_o}, 32'd0);
        check("rst_cipo_en", {31'h0, cipo_en_o}, 32'd0);
        check("rst_rx_data", {24'h0, rx_data_o}, 32'd0);
        check("rst_rx_valid", {31'h0, rx_valid_o}, 32'd0);
        check("rst_tx_ready", {31'h0, tx_ready_o}, 32'd1);
        check("rst_underrun", {31'h0, tx_underrun_o}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        wait_clk(3);
        check_reset_outputs();
        $display("reset state checked");
        rst_n = 1'b1;
        wait_clk(3);

        // queued A5, controller sends 3C
        queue_tx(8'hA5);
        frame_rx[0] = 8'h3C;
        run_frame(1, 1'b0, 8'h00);

        // nothing queued: idle byte and underrun at select
        frame_rx[0] = 8'h5A;
        run_frame(1, 1'b0, 8'h00);

        // two-byte frame, second tx byte queued after the first load
        queue_tx(8'h81);
        frame_rx[0] = 8'hC3;
        frame_rx[1] = 8'h18;
        run_frame(2, 1'b1, 8'h7E);

        // abort after 5 bits, then a full frame
        queue_tx(8'h11);
        abort_frame(8'hF0, 5);
        queue_tx(8'h22);
        frame_rx[0] = 8'h96;
        run_frame(1, 1'b0, 8'h00);

        // reset mid-frame at bit 3
        queue_tx(8'h33);
        cs_n = 1'b0;
        model_load(1'b0);
        wait_clk(4);
        spi_bits(8'hE7, 3);
        rst_n = 1'b0;
        cs_n  = 1'b1;
        #1;
        check_reset_outputs();
        $display("mid-frame reset checked");
        m_full = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(3);
        queue_tx(8'h44);
        frame_rx[0] = 8'h69;
        run_frame(1, 1'b0, 8'h00);

        // SCLK at clk/4, random data both directions
        for (int f = 0; f < 100; f++) begin
            if ($urandom_range(0, 3) != 0) queue_tx(8'($urandom_range(0, 255)));
            frame_rx[0] = 8'($urandom_range(0, 255));
            run_frame(1, 1'b0, 8'h00);
        end

        wait_clk(4);
        check("rx_queue_drained", exp_rx.size(), 32'd0);
        check("tx_queue_drained", exp_tx.size(), 32'd0);
        $display("%0d/%0d checks passed", checks_pass, checks_total);
        $finish;
    end

endmodule

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 SHALL have parameter TxIdleByte, default 8'hFF, byte driven on CIPO when no transmit byte is queued.
REQ-002 SHALL have port clk_i  input  1  system clock; SCLK frequency at most clk_i/4.
REQ-003 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-004 SHALL have port sclk_i  input  1  SPI clock from controller; asynchronous to clk_i.
REQ-005 SHALL have port cs_ni  input  1  SPI chip select, active low; asynchronous.
REQ-006 SHALL have port copi_i  input  1  controller-out data; asynchronous.
REQ-007 SHALL have port cipo_o  output  1  target-out data.
REQ-008 SHALL have port cipo_en_o  output  1  CIPO pad output enable, high while selected.
REQ-009 SHALL have port rx_data_o  output  8  last complete received byte.
REQ-010 SHALL have port rx_valid_o  output  1  one-cycle pulse, rx_data_o updated.
REQ-011 SHALL have port tx_data_i  input  8  byte to transmit.
REQ-012 SHALL have port tx_valid_i  input  1  tx_data_i offered.
REQ-013 SHALL have port tx_ready_o  output  1  holding register empty.
REQ-014 SHALL have port tx_underrun_o  output  1  one-cycle pulse, TxIdleByte substituted.

Function
REQ-015 SHALL support SPI mode 0 only (CPOL=0, CPHA=0), MSB first, 8-bit frames.
REQ-016 SHALL pass sclk_i, cs_ni, copi_i through 2-flop synchronizers; edges detected by comparing synchronized value with its one-cycle-delayed copy.
REQ-017 SHALL implement states IDLE and ACTIVE; IDLE -> ACTIVE on synchronized cs_ni falling edge; any state -> IDLE while synchronized cs_ni high.
REQ-018 SHALL on IDLE->ACTIVE load tx shift register from holding register (freeing it) or, if empty, from TxIdleByte with tx_underrun_o pulsed same cycle; bit counter cleared to 0.
REQ-019 SHALL in ACTIVE drive cipo_en_o=1 and cipo_o=tx shift register bit 7; in IDLE drive cipo_en_o=0, cipo_o=0.
REQ-020 SHALL on each synchronized SCLK rising edge in ACTIVE shift copi into rx shift register LSB and increment 3-bit bit counter (wraps 7->0).
REQ-021 SHALL on the rising edge where counter goes 7->0 register the full byte to rx_data_o and pulse rx_valid_o one cycle; no backpressure, unread bytes overwritten.
REQ-022 SHALL rx_valid_o be high in the cycle after clk_i edge N+2, where N is the first edge sampling raw sclk_i high for bit 8.
REQ-023 SHALL on each synchronized SCLK falling edge in ACTIVE shift tx register left by one if counter != 0, else reload per REQ-018 rules (holding or TxIdleByte + underrun).
REQ-024 SHALL accept tx_data_i into holding register when tx_valid_i && tx_ready_o; tx_ready_o=0 while holding full, =1 the cycle after consumption.
REQ-025 SHALL give cs_ni deassertion priority over a simultaneous SCLK edge: partial byte discarded, no rx_valid_o, bit counter cleared, holding register contents retained.
REQ-026 SHALL ignore SCLK edges and copi while IDLE.

Reset
REQ-027 SHALL on rst_ni low asynchronously force: state IDLE, synchronizers to idle levels (sclk 0, cs_n 1, copi 0), cipo_o=0, cipo_en_o=0, rx_data_o=8'h00, rx_valid_o=0, tx_ready_o=1, tx_underrun_o=0, holding empty, counters 0.
REQ-028 SHALL reset asserted mid-frame abandon the frame; after release the block waits for a fresh cs_ni falling edge.

Verification
REQ-029 SHALL cover: queue 8'hA5, select, clock 8 bits with copi=8'h3C -> cipo shows 1,0,1,0,0,1,0,1; rx_data_o=8'h3C, one rx_valid_o pulse.
REQ-030 SHALL cover: no byte queued, select, 8 clocks -> cipo all 1 (8'hFF), tx_underrun_o one pulse at select.
REQ-031 SHALL cover: queue 8'h81, 8'h7E back-to-back across 16-bit frame -> cipo 8'h81 then 8'h7E, two rx_valid_o pulses, tx_ready_o high after each load.
REQ-032 SHALL cover: deassert cs_ni after 5 bits -> no rx_valid_o, cipo_en_o=0; next frame receives full new byte correctly.
REQ-033 SHALL cover: rst_ni pulsed mid-frame at bit 3 -> all outputs at REQ-027 values immediately; subsequent frame correct.
REQ-034 SHALL cover: SCLK at exactly clk_i/4 with random data over 100 frames -> all bytes match both directions.
